// File: rtl/reset_sequencer.sv
// Staged reset controller: asserts every downstream reset, holds them, then
// releases stage 0..NSTAGES-1 in order, gated by a minimum gap, the previous stage's ready and a timeout.
module reset_sequencer #(
  parameter int NSTAGES = 4,
  parameter int HOLD    = 16,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 64,
  parameter int CW      = 8,
  localparam int IW     = (NSTAGES > 1) ? $clog2(NSTAGES) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ,
  input  logic [NSTAGES-1:0] STAGE_RDY,
  output logic [NSTAGES-1:0] RST_OUT,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR,
  output logic [IW-1:0]      STAGE_IDX
);

  typedef enum logic [1:0] {
    S_ASSERT = 2'd0,
    S_WAIT   = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [IW-1:0]      idx, idx_nxt;
  logic [NSTAGES-1:0] rst_out, rst_out_nxt;
  logic               busy, busy_nxt;
  logic               done, done_nxt;
  logic               err, err_nxt;
  logic               rdy_cur;
  logic               timed_out;
  logic               adv;

  always_comb begin
    rdy_cur = 1'b0;
    for (int i = 0; i < NSTAGES; i++) begin
      if (i == int'(idx)) rdy_cur = STAGE_RDY[i];
    end
  end

  // The counter parks at TIMEOUT-1, so reaching it always forces an advance.
  assign timed_out = (cnt == CW'(TIMEOUT - 1));
  assign adv       = ((cnt >= CW'(GAP - 1)) && rdy_cur) || timed_out;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    rst_out_nxt = rst_out;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    err_nxt     = err;

    if (REQ) begin
      state_nxt   = S_ASSERT;
      cnt_nxt     = '0;
      idx_nxt     = '0;
      rst_out_nxt = '1;
      busy_nxt    = 1'b1;
      err_nxt     = 1'b0;
    end else begin
      case (state)
        S_ASSERT: begin
          if (cnt == CW'(HOLD - 1)) begin
            rst_out_nxt[0] = 1'b0;
            idx_nxt        = '0;
            cnt_nxt        = '0;
            state_nxt      = S_WAIT;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (adv) begin
            if (timed_out && !rdy_cur) err_nxt = 1'b1;
            if (int'(idx) == NSTAGES - 1) begin
              state_nxt = S_RUN;
              done_nxt  = 1'b1;
              busy_nxt  = 1'b0;
            end else begin
              idx_nxt = idx + IW'(1);
              cnt_nxt = '0;
              for (int i = 0; i < NSTAGES; i++) begin
                if (i == int'(idx) + 1) rst_out_nxt[i] = 1'b0;
              end
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        S_RUN: begin
          rst_out_nxt = '0;
        end
        default: begin
          state_nxt = S_ASSERT;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_ASSERT;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      busy    <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      rst_out <= rst_out_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
    end
  end

  assign RST_OUT   = rst_out;
  assign BUSY      = busy;
  assign DONE      = done;
  assign ERR       = err;
  assign STAGE_IDX = idx;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench for reset_sequencer: a timeline model (edges since restart,
// edges since last release) predicts every output each cycle.
module tb_reset_sequencer;
  localparam int NS      = 4;
  localparam int HOLD    = 16;
  localparam int GAP     = 4;
  localparam int TIMEOUT = 64;
  localparam int CW      = 8;
  localparam int IW      = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          REQ = 1'b0;
  logic [NS-1:0] STAGE_RDY = '0;
  logic [NS-1:0] RST_OUT;
  logic          BUSY, DONE, ERR;
  logic [IW-1:0] STAGE_IDX;

  int n_vec = 0;
  int n_bad = 0;

  int m_edge  = 0;
  int m_start = 0;
  int m_last  = 0;
  int m_k     = 0;
  bit m_run   = 1'b0;
  bit m_done  = 1'b0;
  bit m_err   = 1'b0;

  reset_sequencer #(.NSTAGES(NS), .HOLD(HOLD), .GAP(GAP), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .STAGE_RDY(STAGE_RDY),
    .RST_OUT(RST_OUT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .STAGE_IDX(STAGE_IDX)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Reference: stage 0 drops HOLD edges after a restart; stage k drops once
  // it has been GAP edges since stage k-1 with k-1 ready, or TIMEOUT edges regardless.
  task automatic model_edge();
    int  e;
    bit  r;
    bit  adv;
    m_edge++;
    m_done = 1'b0;
    if (RST || REQ) begin
      m_k = 0; m_start = m_edge; m_run = 1'b0; m_err = 1'b0;
    end else if (!m_run) begin
      if (m_k == 0) begin
        if (m_edge - m_start == HOLD) begin
          m_k = 1; m_last = m_edge;
        end
      end else begin
        e   = m_edge - m_last;
        r   = STAGE_RDY[m_k-1];
        adv = (e >= GAP && r) || (e >= TIMEOUT);
        if (adv) begin
          if (!r) m_err = 1'b1;
          if (m_k == NS) begin
            m_run = 1'b1; m_done = 1'b1;
          end else begin
            m_k++; m_last = m_edge;
          end
        end
      end
    end
  endtask

  task automatic step();
    logic [NS-1:0] exp_rst;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    for (int i = 0; i < NS; i++) exp_rst[i] = (i >= m_k);
    chk("rst_out", 32'(RST_OUT), 32'(exp_rst));
    chk("busy", 32'(BUSY), 32'(!m_run));
    chk("done", 32'(DONE), 32'(m_done));
    chk("err", 32'(ERR), 32'(m_err));
    chk("stage_idx", 32'(STAGE_IDX), (m_k == 0) ? 32'd0 : 32'(m_k - 1));
  endtask

  initial begin
    int n;
    int first_rel;
    int j;

    // Reset state
    RST = 1'b1; STAGE_RDY = '1;
    repeat (3) step();
    chk("reset_rst_out", 32'(RST_OUT), 32'hF);
    chk("reset_busy", 32'(BUSY), 32'd1);

    // Nominal sequence: absolute timing from the RST fall
    RST = 1'b0;
    n = 0; first_rel = -1;
    while (n < 200) begin
      step(); n++;
      if (first_rel < 0 && RST_OUT[0] == 1'b0) first_rel = n;
      if (DONE) break;
    end
    chk("t1_stage0_release", 32'(first_rel), 32'd16);
    chk("t1_done_cycle", 32'(n), 32'd32);
    chk("t1_err", 32'(ERR), 32'd0);
    repeat (5) step();

    // Late ready on stage 1, stuck stage 2 forcing a timeout
    REQ = 1'b1; STAGE_RDY = 4'b1101; step();
    REQ = 1'b0;
    repeat (HOLD + GAP + 2) step();
    repeat (10) step();
    STAGE_RDY = 4'b1011;
    repeat (TIMEOUT + 20) step();
    chk("t3_err_sticky", 32'(ERR), 32'd1);
    STAGE_RDY = 4'b0000;
    repeat (5) step();

    // REQ in RUN, then REQ while idx=2
    REQ = 1'b1; STAGE_RDY = '1; step();
    chk("t4_busy", 32'(BUSY), 32'd1);
    chk("t4_err_clr", 32'(ERR), 32'd0);
    REQ = 1'b0;
    repeat (HOLD + 2 * GAP + 1) step();
    REQ = 1'b1; step();
    chk("t5_reassert", 32'(RST_OUT), 32'hF);
    REQ = 1'b0;
    repeat (HOLD + 6) step();

    // RST and REQ together, REQ held afterwards
    RST = 1'b1; REQ = 1'b1; step();
    RST = 1'b0;
    repeat (6) step();
    chk("t6_req_held", 32'(RST_OUT), 32'hF);
    REQ = 1'b0;
    repeat (HOLD + 20) step();

    // Randomized phases
    for (int ph = 0; ph < 12; ph++) begin
      STAGE_RDY = NS'($urandom);
      for (int c = 0; c < int'($urandom_range(60, 260)); c++) begin
        if ($urandom_range(0, 7) == 0) begin
          j = int'($urandom_range(0, NS - 1));
          STAGE_RDY[j] = ~STAGE_RDY[j];
        end
        if (REQ) REQ = ($urandom_range(0, 2) != 0);
        else     REQ = ($urandom_range(0, 149) == 0);
        RST = ($urandom_range(0, 299) == 0);
        step();
      end
    end
    RST = 1'b0; REQ = 1'b0; STAGE_RDY = '1;
    repeat (HOLD + NS * GAP + 5) step();
    chk("final_busy", 32'(BUSY), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
